v_line_sequencer: RTL
=====================

// Module: v_line_sequencer
// PURPOSE
//  Frame-level sequencer for the vertical-compensation path of split_compensate.
//  Steps the line counter over one frame and drives the vertical address generator.
//  Captures each shifted source address and hands it, with the destination line address, to the line copy mover.
//  Flags lines whose shifted source lies outside the frame as blank, so the mover fills them black.
// PARAMETERS
//  NUM_LINES      480   visible lines per frame; o_y_cnt runs 1..NUM_LINES
//  LINE_PIXELS    640   pixels per line; driven constant on o_x_cnt
//  LINE_STRIDE    4096  bytes per line in MPMC memory (1024 px x 4 B)
// PORTS
//  i_clk            in   1   clock
//  i_rst            in   1   asynchronous active-high reset
//  i_start          in   1   1-cycle pulse: begin a frame; ignored while o_busy
//  i_frame_base     in   32  source frame base byte address
//  i_dst_base       in   32  destination frame base byte address
//  i_y_off          in   32  vertical shift in lines (unsigned magnitude)
//  i_dir            in   32  0 = up shift, nonzero = down shift
//  o_y_enable       out  1   high while a line address is being requested
//  o_y_cnt          out  11  current line, 1-based
//  o_x_cnt          out  10  constant LINE_PIXELS
//  i_y_done         in   1   address generator done strobe
//  i_new_addr       in   32  shifted source address from address generator
//  o_line_req       out  1   line copy request to mover
//  o_line_src       out  32  source byte address of line
//  o_line_dst       out  32  destination byte address of line
//  o_line_blank     out  1   1 = fill line black, ignore o_line_src
//  i_line_ack       in   1   mover accepted request
//  i_line_done      in   1   1-cycle pulse: mover finished the line
//  o_busy           out  1   frame in progress
//  o_frame_done     out  1   1-cycle pulse after last line completes
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0 except o_x_cnt = LINE_PIXELS. o_y_cnt = 0.
//  i_start in IDLE latches i_frame_base, i_dst_base, i_y_off, i_dir. Later changes have no effect until the next frame.
//  The address generator free-runs and pulses i_y_done about every 3 cycles, independent of o_y_enable.
//  A pulse seen just after o_y_cnt changes is stale.
//  FSM:
//   IDLE      : i_start -> SET_LINE; o_y_cnt <= 1; o_busy <= 1.
//   SET_LINE  : o_y_enable = 1; clear done-pulse counter -> WAIT_ADDR.
//   WAIT_ADDR : count rising edges of i_y_done. On the 2nd edge, go to ISSUE and set o_line_src:
//               - if y_off != 0, o_line_src <= i_new_addr
//               - if y_off == 0, o_line_src <= base + LINE_STRIDE*(y_cnt-1), computed locally
//               o_y_enable drops on leaving WAIT_ADDR.
//   ISSUE     : o_line_req = 1; o_line_src, o_line_dst, o_line_blank stable until i_line_ack.
//               i_line_ack -> WAIT_LINE, and o_line_req drops the next cycle.
//   WAIT_LINE : i_line_done -> NEXT. i_line_done in the same cycle as i_line_ack also counts.
//   NEXT      : y_cnt == NUM_LINES -> FRAME_DONE; otherwise o_y_cnt + 1 -> SET_LINE.
//   FRAME_DONE: o_frame_done = 1 for one cycle; o_busy <= 0 -> IDLE.
//  o_line_dst = dst_base + LINE_STRIDE*(y_cnt-1), 32-bit, wraps modulo 2^32.
//  Source line index s = (y_cnt-1) - y_off (dir 0) or (y_cnt-1) + y_off (dir != 0).
//   Compute s as a 33-bit signed value.
//   o_line_blank = (s < 0) || (s > NUM_LINES-1).
//   y_off >= NUM_LINES blanks every line.
//   y_off == 0 never blanks.
//  i_start while busy: ignored. i_line_done outside WAIT_LINE: ignored.
//  Reset mid-frame: immediate return to IDLE; any outstanding request is dropped, with no o_frame_done.
//  Frame latency: 1 + sum per line of (SET_LINE + WAIT_ADDR + ack wait + done wait + 1) + 1 cycles.
// TESTING
//  - Reset asserted mid-WAIT_LINE at line 7: o_busy, o_line_req, o_y_enable go 0 asynchronously; next i_start restarts at o_y_cnt = 1.
//  - y_off=0, base=0x1000_0000, dst=0x2000_0000, NUM_LINES=4, mover acks and dones instantly:
//    4 requests; src 0x1000_0000, +0x1000, +0x2000, +0x3000; dst the same offsets; blank=0; one o_frame_done.
//  - y_off=2, dir=0, model generator returns base+4096*((y-1)-2):
//    lines 1-2 blank=1, line 3 src=base, line 4 src=base+0x1000.
//  - y_off=2, dir=1, NUM_LINES=4: lines 3-4 blank=1, line 1 src=base+0x2000.
//    i_line_ack delayed 5 cycles: o_line_req and all three line outputs held stable throughout.
//  - Stale-pulse check: generator asserts i_y_done once with a wrong address, then with the correct one.
//    Captured o_line_src equals the second value.
//  - i_start pulsed during a frame: ignored, no restart. y_off=600: all lines blank.

Source files
------------

// File: rtl/v_line_sequencer_if.sv
// Signals between the vertical line sequencer and its neighbours: frame
// control, the vertical address generator and the line copy mover.
interface v_line_sequencer_if;
    logic        i_start;
    logic [31:0] i_frame_base;
    logic [31:0] i_dst_base;
    logic [31:0] i_y_off;
    logic [31:0] i_dir;
    logic        o_y_enable;
    logic [10:0] o_y_cnt;
    logic [9:0]  o_x_cnt;
    logic        i_y_done;
    logic [31:0] i_new_addr;
    // Line request: o_line_req stays high with src/dst/blank frozen until a
    // cycle in which i_line_ack is high; that cycle is the transfer.
    logic        o_line_req;
    logic [31:0] o_line_src;
    logic [31:0] o_line_dst;
    logic        o_line_blank;
    logic        i_line_ack;
    logic        i_line_done;
    logic        o_busy;
    logic        o_frame_done;

    modport master (
        input  i_start, i_frame_base, i_dst_base, i_y_off, i_dir,
        input  i_y_done, i_new_addr, i_line_ack, i_line_done,
        output o_y_enable, o_y_cnt, o_x_cnt, o_line_req, o_line_src,
        output o_line_dst, o_line_blank, o_busy, o_frame_done
    );

    modport slave (
        output i_start, i_frame_base, i_dst_base, i_y_off, i_dir,
        output i_y_done, i_new_addr, i_line_ack, i_line_done,
        input  o_y_enable, o_y_cnt, o_x_cnt, o_line_req, o_line_src,
        input  o_line_dst, o_line_blank, o_busy, o_frame_done
    );
endinterface

// File: rtl/v_line_sequencer.sv
// Frame sequencer for vertical compensation: walks the lines of a frame, collects
// each shifted source address and hands source/destination/blank to the line mover.
module v_line_sequencer #(
    parameter int NUM_LINES   = 480,
    parameter int LINE_PIXELS = 640,
    parameter int LINE_STRIDE = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst,
    v_line_sequencer_if.master bus,
    output logic [2:0]         o_dbg_state
);
    typedef enum logic [2:0] {
        IDLE, SET_LINE, WAIT_ADDR, ISSUE, WAIT_LINE, NEXT, FRAME_DONE
    } state_t;

    localparam logic [31:0] STRIDE   = 32'(LINE_STRIDE);
    localparam logic [32:0] LAST_IDX = 33'(NUM_LINES - 1);
    localparam logic [10:0] LAST_Y   = 11'(NUM_LINES);

    state_t      state, state_nxt;
    logic [31:0] frame_base, dst_base, y_off;
    logic        dir_down;
    logic [10:0] y_cnt;
    logic        busy;
    logic        y_done_q;
    logic        edge_seen;
    logic [31:0] line_src, line_dst;
    logic        line_blank;
    logic        y_enable, line_req, frame_done;

    logic        y_done_rise;
    logic [31:0] line_idx;
    logic [31:0] line_off;
    logic [32:0] src_idx;
    logic        blank_c;

    assign y_done_rise = bus.i_y_done & ~y_done_q;
    assign line_idx    = 32'(y_cnt) - 32'd1;
    assign line_off    = STRIDE * line_idx;

    // Bit 32 of the source index acts as the sign: set means above the frame top.
    always_comb begin
        src_idx = dir_down ? ({1'b0, line_idx} + {1'b0, y_off})
                           : ({1'b0, line_idx} - {1'b0, y_off});
        blank_c = src_idx[32] || (src_idx > LAST_IDX);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        y_enable   = 1'b0;
        line_req   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:       if (bus.i_start) state_nxt = SET_LINE;
            SET_LINE: begin
                y_enable  = 1'b1;
                state_nxt = WAIT_ADDR;
            end
            // The first done edge after the line changes may belong to the old line.
            WAIT_ADDR: begin
                y_enable = 1'b1;
                if (y_done_rise && edge_seen) state_nxt = ISSUE;
            end
            ISSUE: begin
                line_req = 1'b1;
                if (bus.i_line_ack) state_nxt = bus.i_line_done ? NEXT : WAIT_LINE;
            end
            WAIT_LINE:  if (bus.i_line_done) state_nxt = NEXT;
            NEXT:       state_nxt = (y_cnt == LAST_Y) ? FRAME_DONE : SET_LINE;
            FRAME_DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_base <= '0;
            dst_base   <= '0;
            y_off      <= '0;
            dir_down   <= 1'b0;
            y_cnt      <= '0;
            busy       <= 1'b0;
            y_done_q   <= 1'b0;
            edge_seen  <= 1'b0;
            line_src   <= '0;
            line_dst   <= '0;
            line_blank <= 1'b0;
        end else begin
            y_done_q <= bus.i_y_done;
            case (state)
                IDLE: if (bus.i_start) begin
                    frame_base <= bus.i_frame_base;
                    dst_base   <= bus.i_dst_base;
                    y_off      <= bus.i_y_off;
                    dir_down   <= |bus.i_dir;
                    y_cnt      <= 11'd1;
                    busy       <= 1'b1;
                end
                SET_LINE:  edge_seen <= 1'b0;
                WAIT_ADDR: if (y_done_rise) begin
                    edge_seen <= 1'b1;
                    if (edge_seen) begin
                        line_src   <= (y_off != 32'd0) ? bus.i_new_addr : frame_base + line_off;
                        line_dst   <= dst_base + line_off;
                        line_blank <= blank_c;
                    end
                end
                NEXT:       if (y_cnt != LAST_Y) y_cnt <= y_cnt + 11'd1;
                FRAME_DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.o_y_enable   = y_enable;
    assign bus.o_y_cnt      = y_cnt;
    assign bus.o_x_cnt      = 10'(LINE_PIXELS);
    assign bus.o_line_req   = line_req;
    assign bus.o_line_src   = line_src;
    assign bus.o_line_dst   = line_dst;
    assign bus.o_line_blank = line_blank;
    assign bus.o_busy       = busy;
    assign bus.o_frame_done = frame_done;
    assign o_dbg_state      = state;
endmodule
